// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, runtime divisor, parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN for a 2**FIFO_AW-word input FIFO; otherwise a single holding register.
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter int FIFO_AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic [FIFO_AW:0]     tx_level
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic [DATA_BITS-1:0] w_head;
  logic [FIFO_AW:0]     w_level;

  assign w_push = s_valid & s_ready;

`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_BITS-1:0] r_mem [0:DEPTH-1];
  logic [FIFO_AW:0]     r_wptr;
  logic [FIFO_AW:0]     r_rptr;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_head  = r_mem[r_rptr[FIFO_AW-1:0]];
  assign w_level = r_wptr - r_rptr;

  // FIFO pointers; the extra MSB separates full from empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{FIFO_AW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{FIFO_AW{1'b0}}, 1'b1};
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= s_data;
  end
`else
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_v;

  assign w_empty = !r_hold_v;
  assign w_full  = r_hold_v;
  assign w_head  = r_hold;
  assign w_level = {{FIFO_AW{1'b0}}, r_hold_v};

  // single-word holding register; push and pop are mutually exclusive here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
    end else if (w_push) begin
      r_hold   <= s_data;
      r_hold_v <= 1'b1;
    end else if (w_pop) begin
      r_hold_v <= 1'b0;
    end
  end
`endif

  state_t               r_state, w_state_nx;
  logic [DIV_W-1:0]     r_cnt, w_cnt_nx;
  logic [DIV_W-1:0]     r_div;
  logic [BW-1:0]        r_bit, w_bit_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                 r_stop_hi, w_stop_hi_nx;
  logic                 r_par_en, r_par_bit, r_stop2;
  logic                 r_tx, w_tx_nx;
  logic                 w_load;
  logic                 w_tick;
  logic [DIV_W-1:0]     w_div_eff;

  assign w_div_eff = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign w_tick    = (r_cnt == (r_div - DIV_W'(1)));

  // next-state, bit-cell counter and frame-start (pop) decode
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + DIV_W'(1);
    w_bit_nx     = r_bit;
    w_shift_nx   = r_shift;
    w_stop_hi_nx = r_stop_hi;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        if (!w_empty) begin
          w_load     = 1'b1;
          w_pop      = 1'b1;
          w_shift_nx = w_head;
          w_state_nx = ST_START;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
          w_state_nx = ST_DATA;
        end else begin
          w_state_nx = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_cnt_nx   = '0;
          w_shift_nx = r_shift >> 1;
          if (r_bit == BW'(DATA_BITS - 1)) begin
            w_stop_hi_nx = 1'b0;
            w_state_nx   = r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_nx = r_bit + BW'(1);
          end
        end else begin
          w_state_nx = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_cnt_nx     = '0;
          w_stop_hi_nx = 1'b0;
          w_state_nx   = ST_STOP;
        end else begin
          w_state_nx = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_cnt_nx = '0;
          if (r_stop2 && !r_stop_hi) begin
            w_stop_hi_nx = 1'b1;
          end else if (!w_empty) begin
            w_load     = 1'b1;
            w_pop      = 1'b1;
            w_shift_nx = w_head;
            w_state_nx = ST_START;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_state_nx = ST_STOP;
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // line level for the upcoming cycle, so tx_out can be a flop
  always_comb begin
    w_tx_nx = 1'b1;
    case (w_state_nx)
      ST_IDLE:   w_tx_nx = 1'b1;
      ST_START:  w_tx_nx = 1'b0;
      ST_DATA:   w_tx_nx = w_shift_nx[0];
      ST_PARITY: w_tx_nx = r_par_bit;
      ST_STOP:   w_tx_nx = 1'b1;
      default:   w_tx_nx = 1'b1;
    endcase
  end

  // FSM state, counters and per-frame configuration latched at frame start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div     <= DIV_W'(2);
      r_bit     <= '0;
      r_shift   <= '0;
      r_stop_hi <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_bit     <= w_bit_nx;
      r_shift   <= w_shift_nx;
      r_stop_hi <= w_stop_hi_nx;
      r_tx      <= w_tx_nx;
      if (w_load) begin
        r_div     <= w_div_eff;
        r_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        r_par_bit <= (cfg_parity == 2'b10) ? ~^w_head : ^w_head;
        r_stop2   <= cfg_stop2;
      end
    end
  end

  assign tx_out   = r_tx;
  assign s_ready  = !w_full;
  assign tx_level = w_level;
  assign tx_busy  = (r_state != ST_IDLE) || (w_level != '0);

endmodule
